ir_nec_rx: RTL

Parametrised NEC infrared receiver. It is the successor to the fixed-rate IR decoder. It samples the demodulated receiver pin and filters glitches. It measures mark/space widths on a prescaled time base, decodes 32-bit frames and repeat codes, and presents results on a valid/ready interface with overflow reporting. It sits between a GPIO pad and the command-handling logic in the top level.

---
 rtl/ir_nec_rx.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ir_nec_rx.sv
// NEC infrared receiver: synchroniser, glitch filter, 10 us width timing, frame/repeat decode, valid/ready result.
// Define IR_NEC_STRICT_EN to reject frames whose inverse address/command bytes do not match.
module ir_nec_rx #(
   parameter int CLK_HZ        = 25_000_000,
   parameter int TOL_PCT       = 25,
   parameter int FILTER_CYC    = 16,
   parameter int IN_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        ir_input,
   input  logic        ready,
   output logic        valid,
   output logic [31:0] data,
   output logic [7:0]  addr,
   output logic [7:0]  cmd,
   output logic        repeat_f,
   output logic        overflow,
   output logic        err,
   output logic        busy,
   output logic [2:0]  state_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_REP_MARK
   } state_t;

   localparam int   PRESC    = (CLK_HZ / 100_000 < 1) ? 1 : CLK_HZ / 100_000;
   localparam int   PW       = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam int   FW       = $clog2(FILTER_CYC + 1);
   localparam logic IDLE_LVL = (IN_ACTIVE_LOW != 0);

   function automatic logic [10:0] win(input int n_us, input int pct);
      return 11'((n_us * pct) / 1000);
   endfunction

   function automatic logic in_win(input logic [10:0] w, input logic [10:0] lo, input logic [10:0] hi);
      return (w >= lo) && (w <= hi);
   endfunction

   localparam logic [10:0] LM_LO = win(9000, 100 - TOL_PCT), LM_HI = win(9000, 100 + TOL_PCT);
   localparam logic [10:0] LS_LO = win(4500, 100 - TOL_PCT), LS_HI = win(4500, 100 + TOL_PCT);
   localparam logic [10:0] RS_LO = win(2250, 100 - TOL_PCT), RS_HI = win(2250, 100 + TOL_PCT);
   localparam logic [10:0] BM_LO = win(560,  100 - TOL_PCT), BM_HI = win(560,  100 + TOL_PCT);
   localparam logic [10:0] B1_LO = win(1690, 100 - TOL_PCT), B1_HI = win(1690, 100 + TOL_PCT);

   logic [1:0]    sync_q;
   logic          mark_s, filt_q, filt_d, rise, fall, edge_f;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick, sat;
   logic [10:0]   width_q, width_d;
   state_t        state_q, state_d;
   logic [5:0]    bitcnt_q, bitcnt_d;
   logic [31:0]   shreg_q, shreg_d, last_q, last_d, data_q, data_d;
   logic          last_ok_q, last_ok_d, valid_q, valid_d, rep_q, rep_d, ovf_q, ovf_d, err_q;
   logic          err_evt, frame_done, rep_done, strict_ok;

   // Filtered level is 1 for a mark regardless of pin polarity.
   always_comb begin
      mark_s = (IN_ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];
      filt_d = filt_q;
      fcnt_d = '0;
      if (mark_s != filt_q) begin
         if (fcnt_q == FW'(FILTER_CYC - 1)) filt_d = mark_s;
         else                               fcnt_d = fcnt_q + FW'(1);
      end
      rise    = filt_d & ~filt_q;
      fall    = ~filt_d & filt_q;
      edge_f  = rise | fall;
      tick    = (presc_q == PW'(PRESC - 1));
      presc_d = tick ? '0 : presc_q + PW'(1);
      sat     = (width_q == 11'h7FF);
      width_d = width_q;
      if (!enable || edge_f)  width_d = '0;
      else if (tick && !sat)  width_d = width_q + 11'd1;
   end

`ifdef IR_NEC_STRICT_EN
   assign strict_ok = (shreg_q[15:8] == ~shreg_q[7:0]) && (shreg_q[31:24] == ~shreg_q[23:16]);
`else
   assign strict_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= {2{IDLE_LVL}};
         filt_q    <= 1'b0;
         fcnt_q    <= '0;
         presc_q   <= '0;
         width_q   <= '0;
         state_q   <= S_IDLE;
         bitcnt_q  <= '0;
         shreg_q   <= '0;
         last_q    <= '0;
         last_ok_q <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         rep_q     <= 1'b0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], ir_input};
         filt_q    <= filt_d;
         fcnt_q    <= fcnt_d;
         presc_q   <= presc_d;
         width_q   <= width_d;
         state_q   <= state_d;
         bitcnt_q  <= bitcnt_d;
         shreg_q   <= shreg_d;
         last_q    <= last_d;
         last_ok_q <= last_ok_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         rep_q     <= rep_d;
         ovf_q     <= ovf_d;
         err_q     <= err_evt;
      end
   end

   // Every decision is taken on the filtered edge that ends the current mark or space.
   always_comb begin
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      shreg_d    = shreg_q;
      err_evt    = 1'b0;
      frame_done = 1'b0;
      rep_done   = 1'b0;
      case (state_q)
         S_IDLE:       if (rise) state_d = S_LEAD_MARK;
         S_LEAD_MARK:  if (fall) begin
            if (in_win(width_q, LM_LO, LM_HI)) state_d = S_LEAD_SPACE;
            else                               err_evt = 1'b1;
         end
         S_LEAD_SPACE: if (rise) begin
            if (in_win(width_q, LS_LO, LS_HI)) begin
               state_d  = S_BIT_MARK;
               bitcnt_d = '0;
            end else if (in_win(width_q, RS_LO, RS_HI)) state_d = S_REP_MARK;
            else                                        err_evt = 1'b1;
         end
         S_BIT_MARK:   if (fall) begin
            if (in_win(width_q, BM_LO, BM_HI)) state_d = S_BIT_SPACE;
            else                               err_evt = 1'b1;
         end
         S_BIT_SPACE:  if (rise) begin
            if (in_win(width_q, BM_LO, BM_HI) || in_win(width_q, B1_LO, B1_HI)) begin
               shreg_d  = {in_win(width_q, B1_LO, B1_HI), shreg_q[31:1]};
               bitcnt_d = bitcnt_q + 6'd1;
               state_d  = (bitcnt_q == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
            end else err_evt = 1'b1;
         end
         S_STOP_MARK:  if (fall) begin
            state_d = S_IDLE;
            if (in_win(width_q, BM_LO, BM_HI) && strict_ok) frame_done = 1'b1;
            else                                           err_evt    = 1'b1;
         end
         S_REP_MARK:   if (fall) begin
            state_d = S_IDLE;
            if (in_win(width_q, BM_LO, BM_HI) && last_ok_q) rep_done = 1'b1;
            else                                           err_evt  = 1'b1;
         end
         default:      state_d = S_IDLE;
      endcase
      if (state_q != S_IDLE && sat) begin
         err_evt    = 1'b1;
         frame_done = 1'b0;
         rep_done   = 1'b0;
      end
      if (err_evt) state_d = S_IDLE;
      if (!enable) begin
         state_d    = S_IDLE;
         bitcnt_d   = '0;
         err_evt    = 1'b0;
         frame_done = 1'b0;
         rep_done   = 1'b0;
      end
   end

   // Result register: a completion while a result is still pending is dropped and flagged.
   always_comb begin
      busy      = (state_q != S_IDLE);
      state_o   = state_q;
      last_d    = frame_done ? shreg_q : last_q;
      last_ok_d = err_evt ? 1'b0 : (frame_done ? 1'b1 : last_ok_q);
      data_d    = data_q;
      rep_d     = rep_q;
      valid_d   = valid_q;
      ovf_d     = ovf_q;
      if (valid_q && ready) begin
         valid_d = 1'b0;
         ovf_d   = 1'b0;
      end
      if (frame_done || rep_done) begin
         if (!valid_q || ready) begin
            data_d  = frame_done ? shreg_q : last_q;
            rep_d   = rep_done;
            valid_d = 1'b1;
         end else ovf_d = 1'b1;
      end
   end

   assign valid    = valid_q;
   assign data     = data_q;
   assign addr     = data_q[7:0];
   assign cmd      = data_q[23:16];
   assign repeat_f = rep_q;
   assign overflow = ovf_q;
   assign err      = err_q;

endmodule
